interrupt_arbiter: RTL and testbench

//  Sits directly upstream of the CPU interrupt unit. Collects external interrupt lines
//  (timer, UART, keyboard, ...) and software INT requests, and masks and prioritises them.

---
 rtl/interrupt_arbiter_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 31 +++
 rtl/interrupt_arbiter.sv | 161 ++++++++++++++++
 tb/tb_interrupt_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM states and index encoding.
package interrupt_arbiter_pkg;

  localparam int INDEX_W = 4;
  localparam logic [INDEX_W-1:0] RESERVED_INDEX = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } arbState_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises one asynchronous interrupt line and emits a one-cycle pulse on its rising edge.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irqRaw,
  output logic risePulse
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   prevReg;
  logic [SYNC_STAGES:0]   primed;

  // The primed shift keeps a line that is already high at reset release from
  // looking like a fresh edge while the synchroniser fills up.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncReg <= '0;
      prevReg <= 1'b0;
      primed  <= '0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], irqRaw};
      prevReg <= syncReg[SYNC_STAGES-1];
      primed  <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign risePulse = syncReg[SYNC_STAGES-1] & ~prevReg & primed[SYNC_STAGES];

endmodule

// File: rtl/interrupt_arbiter.sv
// Masks and prioritises external and software interrupts, presenting one at a time
// to the CPU interrupt unit and blocking further requests until eret.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int BASE_INDEX  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic               softReq,
  input  logic [3:0]         softIndex,
  input  logic               maskWe,
  input  logic [NUM_SRC-1:0] maskIn,
  input  logic               ack,
  input  logic               eret,
  output logic               interruptSignal,
  output logic [3:0]         interruptIndex,
  output logic [NUM_SRC-1:0] pending,
  output logic               inService
);

  logic [NUM_SRC-1:0] risePulses;
  logic [NUM_SRC-1:0] pendingReg, maskReg, reqVec;
  logic               softPending;
  logic [INDEX_W-1:0] softIndexReg;

  arbState_t          state, nextState;
  logic               sigReg, nextSig, inServiceReg, nextInService;
  logic               latched, nextLatched, winSoft, nextWinSoft;
  logic [INDEX_W-1:0] indexReg, nextIndex, winIndex, nextWinIndex;
  logic [NUM_SRC-1:0] winOneHot, nextWinOneHot;
  logic [NUM_SRC-1:0] clrPending;
  logic               clrSoft;

  logic               anyReq, candSoft;
  logic [INDEX_W-1:0] candIndex;
  logic [NUM_SRC-1:0] candOneHot;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .clk       (clk),
      .rst       (rst),
      .irqRaw    (irqIn[g]),
      .risePulse (risePulses[g])
    );
  end

  // Software request beats everything; otherwise the lowest enabled source wins.
  assign reqVec = pendingReg & maskReg;
  assign anyReq = softPending | (|reqVec);

  always_comb begin
    candSoft   = softPending;
    candIndex  = softIndexReg;
    candOneHot = '0;
    if (!softPending) begin
      candIndex = RESERVED_INDEX;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (reqVec[i]) begin
          candIndex  = INDEX_W'(BASE_INDEX + i);
          candOneHot = NUM_SRC'(1) << i;
        end
      end
    end
  end

  // IDLE spends one edge committing the winner, the next raising the request.
  always_comb begin
    nextState     = state;
    nextSig       = sigReg;
    nextIndex     = indexReg;
    nextInService = inServiceReg;
    nextLatched   = latched;
    nextWinSoft   = winSoft;
    nextWinIndex  = winIndex;
    nextWinOneHot = winOneHot;
    clrPending    = '0;
    clrSoft       = 1'b0;
    case (state)
      IDLE: begin
        if (latched) begin
          nextState   = REQ;
          nextSig     = 1'b0;
          nextIndex   = winIndex;
          nextLatched = 1'b0;
        end else if (anyReq) begin
          nextLatched   = 1'b1;
          nextWinSoft   = candSoft;
          nextWinIndex  = candIndex;
          nextWinOneHot = candOneHot;
        end
      end
      REQ: begin
        if (ack) begin
          clrSoft       = winSoft;
          clrPending    = winSoft ? '0 : winOneHot;
          nextSig       = 1'b1;
          nextInService = 1'b1;
          nextState     = SERVICE;
        end
      end
      SERVICE: begin
        if (!eret) begin
          nextInService = 1'b0;
          nextState     = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sigReg       <= 1'b1;
      indexReg     <= RESERVED_INDEX;
      inServiceReg <= 1'b0;
      latched      <= 1'b0;
      winSoft      <= 1'b0;
      winIndex     <= RESERVED_INDEX;
      winOneHot    <= '0;
    end else begin
      state        <= nextState;
      sigReg       <= nextSig;
      indexReg     <= nextIndex;
      inServiceReg <= nextInService;
      latched      <= nextLatched;
      winSoft      <= nextWinSoft;
      winIndex     <= nextWinIndex;
      winOneHot    <= nextWinOneHot;
    end
  end

  // A fresh edge in the same cycle as its clear keeps the pending bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendingReg   <= '0;
      maskReg      <= '0;
      softPending  <= 1'b0;
      softIndexReg <= RESERVED_INDEX;
    end else begin
      pendingReg <= (pendingReg & ~clrPending) | risePulses;
      if (maskWe) maskReg <= maskIn;
      if (clrSoft) begin
        softPending <= 1'b0;
      end else if (softReq && !softPending) begin
        softPending  <= 1'b1;
        softIndexReg <= softIndex;
      end
    end
  end

  assign interruptSignal = sigReg;
  assign interruptIndex  = indexReg;
  assign pending         = pendingReg;
  assign inService       = inServiceReg;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter with hand-computed expectations.
module tb_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irqIn = '0;
  logic       softReq = 1'b0;
  logic [3:0] softIndex = '0;
  logic       maskWe = 1'b0;
  logic [3:0] maskIn = '0;
  logic       ack = 1'b0;
  logic       eret = 1'b1;
  logic       interruptSignal;
  logic [3:0] interruptIndex;
  logic [3:0] pending;
  logic       inService;

  int errorCount = 0;
  int checkCount = 0;

  interrupt_arbiter #(.NUM_SRC(4), .SYNC_STAGES(2), .BASE_INDEX(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .irqIn           (irqIn),
    .softReq         (softReq),
    .softIndex       (softIndex),
    .maskWe          (maskWe),
    .maskIn          (maskIn),
    .ack             (ack),
    .eret            (eret),
    .interruptSignal (interruptSignal),
    .interruptIndex  (interruptIndex),
    .pending         (pending),
    .inService       (inService)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of pulses; irqIn is a level and stays as given.
  task automatic applyStimulus(input logic [3:0] irq, input logic sReq, input logic [3:0] sIdx,
                               input logic mWe, input logic [3:0] mIn, input logic ackV, input logic eretV);
    irqIn = irq; softReq = sReq; softIndex = sIdx;
    maskWe = mWe; maskIn = mIn; ack = ackV; eret = eretV;
    tick();
    softReq = 1'b0; maskWe = 1'b0; ack = 1'b0; eret = 1'b1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
  endtask

  task automatic waitRequest(input string tag, input int maxCycles);
    int n = 0;
    while (interruptSignal !== 1'b0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(interruptSignal), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    checkOutput("rstSig", 32'(interruptSignal), 32'd1);
    checkOutput("rstIdx", 32'(interruptIndex), 32'd0);
    checkOutput("rstPend", 32'(pending), 32'd0);
    checkOutput("rstInSvc", 32'(inService), 32'd0);
    rst = 1'b0;
    idle(4);

    // Test 1: exact latency and ack handshake
    applyStimulus(4'b0000, 0, 0, 1, 4'b0001, 0, 1);
    applyStimulus(4'b0001, 0, 0, 0, 0, 0, 1);
    idle(2);
    irqIn = 4'b0000;
    tick();
    checkOutput("t1SigEarly", 32'(interruptSignal), 32'd1);
    tick();
    checkOutput("t1SigLow", 32'(interruptSignal), 32'd0);
    checkOutput("t1Idx", 32'(interruptIndex), 32'd1);
    checkOutput("t1Pend", 32'(pending), 32'b0001);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1, 1);
    checkOutput("t1AckSig", 32'(interruptSignal), 32'd1);
    checkOutput("t1AckPend", 32'(pending), 32'd0);
    checkOutput("t1InSvc", 32'(inService), 32'd1);
    applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0);
    checkOutput("t1Eret", 32'(inService), 32'd0);
    checkOutput("t1IdxHold", 32'(interruptIndex), 32'd1);

    // Test 2: simultaneous edges, lowest source first
    applyReset();
    applyStimulus(4'b0000, 0, 0, 1, 4'b1111, 0, 1);
    applyStimulus(4'b1010, 0, 0, 0, 0, 0, 1);
    waitRequest("t2Req1", 10);
    checkOutput("t2Idx1", 32'(interruptIndex), 32'd2);
    checkOutput("t2Pend", 32'(pending), 32'b1010);
    irqIn = 4'b0000;
    applyStimulus(4'b0000, 0, 0, 0, 0, 1, 1);
    checkOutput("t2PendAck", 32'(pending), 32'b1000);
    applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0);
    waitRequest("t2Req2", 10);
    checkOutput("t2Idx2", 32'(interruptIndex), 32'd4);

    // Test 3: software request during service, second soft request dropped
    applyStimulus(4'b0000, 0, 0, 0, 0, 1, 1);
    applyStimulus(4'b0001, 0, 0, 0, 0, 0, 1);
    applyStimulus(4'b0001, 1, 4'd9, 0, 0, 0, 1);
    applyStimulus(4'b0001, 1, 4'd5, 0, 0, 0, 1);
    idle(6);
    checkOutput("t3HoldSig", 32'(interruptSignal), 32'd1);
    checkOutput("t3InSvc", 32'(inService), 32'd1);
    checkOutput("t3Pend", 32'(pending), 32'b0001);
    applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0);
    waitRequest("t3ReqSoft", 10);
    checkOutput("t3IdxSoft", 32'(interruptIndex), 32'd9);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1, 1);
    applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0);
    waitRequest("t3ReqExt", 10);
    checkOutput("t3IdxExt", 32'(interruptIndex), 32'd1);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1, 1);
    applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0);
    idle(6);
    checkOutput("t3NoMore", 32'(interruptSignal), 32'd1);

    // Test 4: masked source keeps pending, enabled later
    applyReset();
    applyStimulus(4'b0100, 0, 0, 0, 0, 0, 1);
    idle(6);
    checkOutput("t4Pend", 32'(pending), 32'b0100);
    checkOutput("t4NoReq", 32'(interruptSignal), 32'd1);
    applyStimulus(4'b0100, 0, 0, 1, 4'b0100, 0, 1);
    waitRequest("t4Req", 10);
    checkOutput("t4Idx", 32'(interruptIndex), 32'd3);

    // Test 6: reset in REQ with irqIn[2] still held high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6Sig", 32'(interruptSignal), 32'd1);
    checkOutput("t6Pend", 32'(pending), 32'd0);
    checkOutput("t6Idx", 32'(interruptIndex), 32'd0);
    checkOutput("t6InSvc", 32'(inService), 32'd0);
    idle(8);
    checkOutput("t6HeldPend", 32'(pending), 32'd0);
    applyStimulus(4'b0100, 0, 0, 1, 4'b1111, 0, 1);
    idle(6);
    checkOutput("t6MaskCleared", 32'(interruptSignal), 32'd1);
    irqIn = 4'b0000;

    // Test 5: committed winner, set beats clear on ack
    applyReset();
    applyStimulus(4'b0000, 0, 0, 1, 4'b0001, 0, 1);
    applyStimulus(4'b0001, 0, 0, 0, 0, 0, 1);
    idle(2);
    irqIn = 4'b0000;
    waitRequest("t5Req", 10);
    applyStimulus(4'b0000, 0, 0, 1, 4'b0000, 0, 1);
    applyStimulus(4'b0001, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("t5SigHeld", 32'(interruptSignal), 32'd0);
    checkOutput("t5IdxHeld", 32'(interruptIndex), 32'd1);
    applyStimulus(4'b0001, 0, 0, 0, 0, 1, 1);
    checkOutput("t5PendSet", 32'(pending), 32'b0001);
    checkOutput("t5AckSig", 32'(interruptSignal), 32'd1);
    checkOutput("t5InSvc", 32'(inService), 32'd1);
    applyStimulus(4'b0000, 0, 0, 0, 0, 0, 0);
    idle(6);
    checkOutput("t5MaskedIdle", 32'(interruptSignal), 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
